// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Code 2'b11 has no member and is handled as "no parity" by the receiver.
  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_mode_e;

  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    int d;
    d = clk_hz / (baud * ovs);
    return (d < 1) ? 1 : d;
  endfunction

  // First of the three consecutive majority-vote sample points within a bit.
  function automatic int sample_first(input int ovs);
    return ovs / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_ovs_if.sv
// Received-word handshake bundle: the receiver is the master, the consumer the slave.
interface uart_rx_ovs_if #(
  parameter int D_BITS = 8
);
  logic [D_BITS-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_frame_err;
  logic              o_parity_err;
  logic              o_overrun;

  modport master (
    output o_data, o_valid, o_frame_err, o_parity_err, o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_frame_err, o_parity_err, o_overrun,
    output i_ready
  );
endinterface

// File: rtl/uart_ovs_tick.sv
// Oversample tick divider: one-cycle pulse every DIV cycles while enabled,
// cleared when disabled and restarted synchronously on i_restart.
module uart_ovs_tick #(
  parameter int DIV = 1
) (
  input  logic i_clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_restart,
  output logic o_tick
);
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: defaults first so every path assigns each output; a missed branch would infer a latch.
    cnt_d  = cnt_q;
    o_tick = 1'b0;
    if (i_restart || !i_en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      o_tick = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values whatever the block evaluation order.
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with 2-of-3 majority voting and a valid/ready output.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BAUD    = 921_600,
  parameter int OVS     = 16,
  parameter int D_BITS  = 8,
  parameter int SP_BITS = 1
) (
  input  logic          i_clk,
  input  logic          reset,
  input  logic          i_rx,
`ifdef UART_RX_PARITY_EN
  input  logic [1:0]    i_parity_mode,
`endif
  uart_rx_ovs_if.master rx_if
);
  localparam int            DIV       = calc_div(CLK_HZ, BAUD, OVS);
  localparam int            TW        = $clog2(OVS);
  localparam logic [TW-1:0] T_S0      = TW'(sample_first(OVS));
  localparam logic [TW-1:0] T_S1      = TW'(sample_first(OVS) + 1);
  localparam logic [TW-1:0] T_S2      = TW'(sample_first(OVS) + 2);
  localparam logic [TW-1:0] T_LAST    = TW'(OVS - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(D_BITS - 1);
  localparam logic          LAST_STOP = 1'(SP_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  parity_mode_e  mode;
  assign mode = parity_mode_e'(i_parity_mode);
`else
  localparam bit PAR_EN = 1'b0;
  parity_mode_e  mode;
  assign mode = PAR_NONE;
`endif

  rx_state_e         state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic              armed_q, armed_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [3:0]        bit_q, bit_d;
  logic              stop_q, stop_d;
  logic [2:0]        samp_q, samp_d;
  logic [D_BITS-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              ferr_acc_q, ferr_acc_d;
  logic              perr_acc_q, perr_acc_d;
  logic [D_BITS-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              perr_q, perr_d;
  logic              ovr_q, ovr_d;

  logic rx_s, tick, maj, decide, start_det, complete;

  assign rx_s      = sync_q[1];
  assign start_det = (state_q == ST_IDLE) && armed_q && !rx_s;
  assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign decide    = tick && (tcnt_q == T_LAST);

  uart_ovs_tick #(.DIV(DIV)) u_tick (
    .i_clk     (i_clk),
    .reset     (reset),
    .i_en      (state_q != ST_IDLE),
    .i_restart (start_det),
    .o_tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[0], i_rx};
    armed_d    = armed_q;
    tcnt_d     = tcnt_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    samp_d     = samp_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    ferr_acc_d = ferr_acc_q;
    perr_acc_d = perr_acc_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    ovr_d      = ovr_q;
    complete   = 1'b0;

    if (tick) begin
      tcnt_d = (tcnt_q == T_LAST) ? '0 : tcnt_q + 1'b1;
      if (tcnt_q == T_S0) samp_d[0] = rx_s;
      if (tcnt_q == T_S1) samp_d[1] = rx_s;
      if (tcnt_q == T_S2) samp_d[2] = rx_s;
    end

    case (state_q)
      ST_IDLE: begin
        tcnt_d = '0;
        // Re-arm only once the line has been seen high since the last frame.
        if (rx_s) armed_d = 1'b1;
        if (start_det) begin
          state_d    = ST_START;
          bit_d      = '0;
          stop_d     = 1'b0;
          par_d      = 1'b0;
          ferr_acc_d = 1'b0;
          perr_acc_d = 1'b0;
        end
      end
      ST_START: if (decide) state_d = maj ? ST_IDLE : ST_DATA;
      ST_DATA: if (decide) begin
        shreg_d = {maj, shreg_q[D_BITS-1:1]};
        par_d   = par_q ^ maj;
        bit_d   = bit_q + 1'b1;
        if (bit_q == LAST_BIT) begin
          bit_d   = '0;
          state_d = (PAR_EN && (mode == PAR_EVEN || mode == PAR_ODD)) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (decide) begin
        perr_acc_d = par_q ^ maj ^ (mode == PAR_ODD);
        state_d    = ST_STOP;
      end
      ST_STOP: if (decide) begin
        if (!maj) ferr_acc_d = 1'b1;
        stop_d = stop_q + 1'b1;
        if (stop_q == LAST_STOP) begin
          complete = 1'b1;
          armed_d  = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A finished frame is only taken when the holding register is free or being emptied.
    if (complete && (!valid_q || rx_if.i_ready)) begin
      data_d  = shreg_q;
      ferr_d  = ferr_acc_d;
      perr_d  = perr_acc_q;
      valid_d = 1'b1;
      ovr_d   = 1'b0;
    end else if (complete) begin
      ovr_d = 1'b1;
    end else if (valid_q && rx_if.i_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sync_q     <= 2'b11;
      armed_q    <= 1'b0;
      tcnt_q     <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      samp_q     <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      ferr_acc_q <= 1'b0;
      perr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      armed_q    <= armed_d;
      tcnt_q     <= tcnt_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      samp_q     <= samp_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      ferr_acc_q <= ferr_acc_d;
      perr_acc_q <= perr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_if.o_data       = data_q;
  assign rx_if.o_valid      = valid_q;
  assign rx_if.o_frame_err  = ferr_q;
  assign rx_if.o_parity_err = PAR_EN ? perr_q : 1'b0;
  assign rx_if.o_overrun    = ovr_q;

endmodule
